// File: rtl/pwls_channel_alu_unit.sv
// pwls_channel_alu_unit: one PWL synth voice -- phase accumulator, waveform shaper,
// slope/offset clamp and amplitude multiply. Define PWLS_DETUNE_EN for the detuned second oscillator.
`ifndef CHANNEL_MODE_BITS
`define CHANNEL_MODE_BITS 2
`endif

module pwls_channel_alu_unit #(
    parameter int BITS            = 12,
    parameter int OCT_BITS        = 3,
    parameter int MANTISSA_BITS   = 10,
    parameter int DETUNE_EXP_BITS = 3,
    parameter int SLOPE_EXP_BITS  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [MANTISSA_BITS-1:0]      mantissa,
    input  logic [OCT_BITS-1:0]           octave,
    input  logic [DETUNE_EXP_BITS-1:0]    detune_exp,
    input  logic [BITS-1:0]               tri_offset,
    input  logic [SLOPE_EXP_BITS-1:0]     slope_exp,
    input  logic [BITS-4:0]               slope_offset,
    input  logic [BITS-3:0]               amp,
    input  logic [`CHANNEL_MODE_BITS-1:0] channel_mode,
    output logic [BITS-1:0]               phase,
    output logic signed [BITS-1:0]        out
);
    localparam int ACC_W = BITS + MANTISSA_BITS;
    // Wide enough that t << slope_exp plus a sign bit can never overflow.
    localparam int SW    = BITS + (1 << SLOPE_EXP_BITS);
    localparam int PW    = 2 * BITS - 1;
    localparam logic [BITS-2:0] M = '1;

    typedef enum logic [`CHANNEL_MODE_BITS-1:0] {
        MODE_TRI    = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_SQUARE = 2'd2,
        MODE_MUTE   = 2'd3
    } mode_e;

    function automatic logic signed [BITS-1:0] shape(
        input logic [BITS-1:0]           ph,
        input logic [BITS-1:0]           toff,
        input logic [SLOPE_EXP_BITS-1:0] sexp,
        input logic [BITS-4:0]           soff,
        input logic [BITS-3:0]           gain,
        input mode_e                     mode
    );
        logic [BITS-1:0]        p;
        logic [BITS-2:0]        t;
        logic signed [SW-1:0]   s_wide;
        logic [BITS-2:0]        s;
        logic signed [BITS-1:0] w;
        logic signed [PW-1:0]   prod;
        p = ph + toff;
        case (mode)
            MODE_TRI:    t = p[BITS-1] ? ~p[BITS-2:0] : p[BITS-2:0];
            MODE_SAW:    t = p[BITS-1:1];
            MODE_SQUARE: t = p[BITS-1] ? M : '0;
            default:     t = '0;
        endcase
        s_wide = (SW'(t) << sexp) - SW'({soff, 2'b00});
        if (s_wide < 0)
            s = '0;
        else if (s_wide > $signed(SW'(M)))
            s = M;
        else
            s = s_wide[BITS-2:0];
        w    = $signed({s, 1'b0} - BITS'(1 << (BITS - 1)));
        prod = PW'(w) * PW'($signed({1'b0, gain}));
        // Arithmetic shift of the full product gives round-toward-minus-infinity.
        return (mode == MODE_MUTE) ? '0 : BITS'(prod >>> (BITS - 2));
    endfunction

    logic [ACC_W-1:0]       r_acc_a;
    logic [ACC_W-1:0]       w_inc;
    logic signed [BITS-1:0] w_f_a;
    logic signed [BITS-1:0] w_out_next;

    assign w_inc = ACC_W'({1'b1, mantissa}) << octave;
    assign w_f_a = shape(r_acc_a[ACC_W-1 -: BITS], tri_offset, slope_exp, slope_offset, amp,
                         mode_e'(channel_mode));

`ifdef PWLS_DETUNE_EN
    logic [ACC_W-1:0]       r_acc_b;
    logic [ACC_W-1:0]       w_inc_b;
    logic signed [BITS-1:0] w_f_b;
    logic signed [BITS:0]   w_sum;

    assign w_inc_b    = w_inc + (w_inc >> (MANTISSA_BITS - int'(detune_exp)));
    assign w_f_b      = shape(r_acc_b[ACC_W-1 -: BITS], tri_offset, slope_exp, slope_offset, amp,
                              mode_e'(channel_mode));
    assign w_sum      = {w_f_a[BITS-1], w_f_a} + {w_f_b[BITS-1], w_f_b};
    assign w_out_next = (detune_exp != '0) ? BITS'(w_sum >>> 1) : w_f_a;
`else
    logic w_unused_detune;
    assign w_unused_detune = ^detune_exp;
    assign w_out_next      = w_f_a;
`endif

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc_a <= '0;
            out     <= '0;
`ifdef PWLS_DETUNE_EN
            r_acc_b <= '0;
`endif
        end else begin
            r_acc_a <= r_acc_a + w_inc;
            out     <= w_out_next;
`ifdef PWLS_DETUNE_EN
            r_acc_b <= r_acc_b + w_inc_b;
`endif
        end
    end

    assign phase = r_acc_a[ACC_W-1 -: BITS];

endmodule

// File: tb/tb_pwls_channel_alu_unit.sv
// Self-checking bench for pwls_channel_alu_unit: directed vector table, hand sequences,
// and randomized segments against an integer-arithmetic voice model (honours PWLS_DETUNE_EN).
`ifndef CHANNEL_MODE_BITS
`define CHANNEL_MODE_BITS 2
`endif

module tb_pwls_channel_alu_unit;
    localparam int  ACC_MOD = 1 << 22;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  mantissa;
    logic [2:0]  octave;
    logic [2:0]  detune_exp;
    logic [11:0] tri_offset;
    logic [3:0]  slope_exp;
    logic [8:0]  slope_offset;
    logic [9:0]  amp;
    logic [`CHANNEL_MODE_BITS-1:0] channel_mode;
    logic [11:0] phase;
    logic signed [11:0] out_w;

    int n_checks = 0;
    int n_errors = 0;

    longint m_acc_a, m_acc_b;
    int     m_out;

    pwls_channel_alu_unit dut (
        .clk(clk), .reset(reset), .mantissa(mantissa), .octave(octave),
        .detune_exp(detune_exp), .tri_offset(tri_offset), .slope_exp(slope_exp),
        .slope_offset(slope_offset), .amp(amp), .channel_mode(channel_mode),
        .phase(phase), .out(out_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mant; int oct; int toff; int sexp; int soff; int gain; int mode;
        int exp_out; int exp_phase;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Voice transfer function from the waveform rules, in plain integer arithmetic.
    function automatic int model_f(longint acc, int toff, int sexp, int soff, int gain, int mode);
        int p, t, s, w;
        if (mode == 3) return 0;
        p = (int'(acc / 1024) + toff) % 4096;
        if (mode == 0)      t = (p >= 2048) ? 4095 - p : p;
        else if (mode == 1) t = p / 2;
        else                t = (p >= 2048) ? 2047 : 0;
        s = t * (1 << sexp) - soff * 4;
        if (s < 0) s = 0;
        if (s > 2047) s = 2047;
        w = 2 * s - 2048;
        return (w * gain) >>> 10;
    endfunction

    task automatic step();
        longint inc, incb;
        int fa, fb, nxt;
        if (reset) begin
            m_acc_a = 0; m_acc_b = 0; m_out = 0;
        end else begin
            inc = longint'(1024 + int'(mantissa)) << int'(octave);
            fa  = model_f(m_acc_a, int'(tri_offset), int'(slope_exp), int'(slope_offset),
                          int'(amp), int'(channel_mode));
            nxt = fa;
`ifdef PWLS_DETUNE_EN
            incb = inc + (inc >> (10 - int'(detune_exp)));
            fb   = model_f(m_acc_b, int'(tri_offset), int'(slope_exp), int'(slope_offset),
                           int'(amp), int'(channel_mode));
            if (detune_exp != 0) nxt = (fa + fb) >>> 1;
            m_acc_b = (m_acc_b + incb) % ACC_MOD;
`else
            incb = 0; fb = 0;
`endif
            m_out   = nxt;
            m_acc_a = (m_acc_a + inc) % ACC_MOD;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_phase"}, int'(phase), int'(m_acc_a / 1024));
        check({tag, "_out"}, int'(out_w), m_out);
    endtask

    task automatic apply_vec(input vec_t v);
        mantissa = v.mant[9:0]; octave = v.oct[2:0]; tri_offset = v.toff[11:0];
        slope_exp = v.sexp[3:0]; slope_offset = v.soff[8:0]; amp = v.gain[9:0];
        channel_mode = v.mode[`CHANNEL_MODE_BITS-1:0];
    endtask

    initial begin
        reset = 1'b1; mantissa = '0; octave = '0; detune_exp = '0; tri_offset = '0;
        slope_exp = '0; slope_offset = '0; amp = 10'd1023; channel_mode = '0;
        m_acc_a = 0; m_acc_b = 0; m_out = 0;

        //           mant  oct toff sexp soff gain mode  out  phase
        vecs[0]  = '{0,    0,  0,    0,  0,   1023, 0, -2046, 1};
        vecs[1]  = '{0,    3,  2048, 0,  0,   1023, 0,  2044, 8};
        vecs[2]  = '{0,    0,  2048, 0,  0,   0,    0,     0, 1};
        vecs[3]  = '{1023, 0,  0,    1,  256, 1023, 0, -2046, 1};
        vecs[4]  = '{0,    0,  1000, 1,  256, 1023, 0,   -96, 1};
        vecs[5]  = '{0,    0,  1536, 1,  256, 1023, 0,  2044, 1};
        vecs[6]  = '{0,    0,  2048, 0,  0,   1023, 3,     0, 1};
        vecs[7]  = '{0,    0,  2048, 0,  0,   1023, 2,  2044, 1};
        vecs[8]  = '{0,    0,  0,    0,  0,   1023, 2, -2046, 1};
        vecs[9]  = '{0,    0,  1000, 0,  0,   1023, 1, -1047, 1};
        vecs[10] = '{0,    0,  2048, 0,  0,   512,  0,  1023, 1};
        vecs[11] = '{1023, 7,  0,    0,  0,   1023, 0, -2046, 255};
        vecs[12] = '{0,    0,  3000, 0,  0,   1023, 0,   141, 1};

        // Each vector: hold reset, release, first sample reflects acc = 0.
        for (int i = 0; i < 13; i++) begin
            reset = 1'b1;
            apply_vec(vecs[i]);
            step();
            step();
            check($sformatf("v%0d_rst_out", i), int'(out_w), 0);
            check($sformatf("v%0d_rst_phase", i), int'(phase), 0);
            reset = 1'b0;
            step();
            check($sformatf("v%0d_out", i), int'(out_w), vecs[i].exp_out);
            check($sformatf("v%0d_phase", i), int'(phase), vecs[i].exp_phase);
        end

        // Frequency: octave 3 advances phase by 8 per cycle.
        reset = 1'b1; mantissa = '0; octave = 3'd3; step();
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            check($sformatf("oct3_phase%0d", k), int'(phase), 8 * k);
        end

        // Frequency: mantissa 1023 adds 2047 to the accumulator per cycle.
        reset = 1'b1; mantissa = 10'd1023; octave = '0; step();
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("mant_phase%0d", k), int'(phase), (k * 2047) / 1024);
        end

        // Mute and zero gain hold out at 0 across many phases.
        reset = 1'b1; octave = 3'd7; mantissa = 10'd333; step();
        reset = 1'b0; channel_mode = 2'd3; amp = 10'd1023; tri_offset = 12'd77;
        for (int k = 0; k < 10; k++) begin
            step();
            check("mute_out", int'(out_w), 0);
        end
        channel_mode = 2'd0; amp = '0;
        step();
        for (int k = 0; k < 10; k++) begin
            step();
            check("amp0_out", int'(out_w), 0);
        end

        // Randomized segments against the model; parameters change without reset.
        reset = 1'b1; step(); reset = 1'b0;
        for (int seg = 0; seg < 40; seg++) begin
            mantissa     = 10'($urandom_range(0, 1023));
            octave       = 3'($urandom_range(0, 7));
            detune_exp   = (seg % 4 == 0) ? 3'd0 : ((seg % 4 == 1) ? 3'd7 : 3'($urandom_range(0, 7)));
            tri_offset   = 12'($urandom_range(0, 4095));
            slope_exp    = 4'($urandom_range(0, 3));
            slope_offset = 9'($urandom_range(0, 511));
            if (seg % 5 == 0) begin slope_exp = '0; slope_offset = '0; end
            amp          = 10'($urandom_range(0, 1023));
            channel_mode = 2'($urandom_range(0, 3));
            reset        = (seg % 9 == 8);
            for (int c = 0; c < 20; c++) begin
                step();
                check_model($sformatf("rnd%0d", seg));
                reset = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
